load_store_unit: RTL and testbench

//  Sits directly upstream of the byte-addressable, big-endian data memory, between execute stage and memory.

---
 rtl/load_store_unit.sv | 172 +++++++++++++++++
 tb/tb_load_store_unit.sv | 216 +++++++++++++++++++++
 2 files changed

// File: rtl/load_store_unit.sv
// Load/store unit: turns byte/half/word requests into word-aligned big-endian memory cycles.
// Optional misalignment trap enabled by defining LSU_ALIGN_TRAP_EN.
module load_store_unit #(
    parameter int MEM_AW = 12
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_wr,
    input  logic [1:0]  req_size,
    input  logic        req_sign,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        rsp_valid,
    output logic [31:0] rsp_rdata,
    output logic        rsp_misalign,
    output logic        dm_cs,
    output logic        dm_rd,
    output logic        dm_wr,
    output logic [31:0] dm_addr,
    output logic [31:0] dm_din,
    input  logic [31:0] dm_dout
);

    typedef enum logic [1:0] {IDLE, RD, WR, RESP} state_e;

    state_e            state_q, state_d;
    logic              wr_q, sign_q, mis_q;
    logic [1:0]        size_q;
    logic [MEM_AW-1:0] addr_q;
    logic [31:0]       wdata_q, rbuf_q;

    logic        accept, mis_now;
    logic [1:0]  off;
    logic [7:0]  byte_sel;
    logic [15:0] half_sel;
    logic [31:0] ld_data, merged;
    logic        unused_addr_bits;

    // Addresses wrap inside the memory window; upper request bits are dropped.
    assign unused_addr_bits = ^req_addr[31:MEM_AW];

    assign accept = req_valid && (state_q == IDLE);
    assign off    = addr_q[1:0];

`ifdef LSU_ALIGN_TRAP_EN
    assign mis_now = ((req_size == 2'b01) && req_addr[0]) ||
                     (req_size[1] && (req_addr[1:0] != 2'b00));
`else
    assign mis_now = 1'b0;
`endif

    // NOTE: state and every latched field are reset so outputs are defined straight out of reset.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
            wr_q    <= 1'b0;
            sign_q  <= 1'b0;
            mis_q   <= 1'b0;
            size_q  <= 2'b00;
            addr_q  <= '0;
            wdata_q <= '0;
            rbuf_q  <= '0;
        end else begin
            state_q <= state_d;
            if (accept) begin
                wr_q    <= req_wr;
                sign_q  <= req_sign;
                mis_q   <= mis_now;
                size_q  <= req_size;
                addr_q  <= req_addr[MEM_AW-1:0];
                wdata_q <= req_wdata;
            end
            if (state_q == RD) begin
                rbuf_q <= dm_dout;
            end
        end
    end

    // NOTE: every comb output gets a default first so no latch is inferred.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    if (mis_now)                      state_d = RESP;
                    else if (!req_wr || !req_size[1]) state_d = RD;
                    else                              state_d = WR;
                end
            end
            RD:      state_d = wr_q ? WR : RESP;
            WR:      state_d = RESP;
            default: state_d = IDLE;
        endcase
    end

    // Big-endian lane selection: offset 0 is the most significant byte.
    always_comb begin
        byte_sel = rbuf_q[7:0];
        case (off)
            2'd0:    byte_sel = rbuf_q[31:24];
            2'd1:    byte_sel = rbuf_q[23:16];
            2'd2:    byte_sel = rbuf_q[15:8];
            default: byte_sel = rbuf_q[7:0];
        endcase
    end

    assign half_sel = off[1] ? rbuf_q[15:0] : rbuf_q[31:16];

    always_comb begin
        ld_data = rbuf_q;
        case (size_q)
            2'b00:   ld_data = {{24{sign_q & byte_sel[7]}}, byte_sel};
            2'b01:   ld_data = {{16{sign_q & half_sel[15]}}, half_sel};
            default: ld_data = rbuf_q;
        endcase
    end

    always_comb begin
        merged = wdata_q;
        case (size_q)
            2'b00: begin
                merged = rbuf_q;
                case (off)
                    2'd0:    merged[31:24] = wdata_q[7:0];
                    2'd1:    merged[23:16] = wdata_q[7:0];
                    2'd2:    merged[15:8]  = wdata_q[7:0];
                    default: merged[7:0]   = wdata_q[7:0];
                endcase
            end
            2'b01: begin
                merged = rbuf_q;
                if (off[1]) merged[15:0]  = wdata_q[15:0];
                else        merged[31:16] = wdata_q[15:0];
            end
            default: merged = wdata_q;
        endcase
    end

    always_comb begin
        req_ready    = 1'b0;
        rsp_valid    = 1'b0;
        rsp_rdata    = '0;
        rsp_misalign = 1'b0;
        dm_cs        = 1'b0;
        dm_rd        = 1'b0;
        dm_wr        = 1'b0;
        dm_addr      = '0;
        dm_din       = '0;
        case (state_q)
            IDLE: req_ready = 1'b1;
            RD: begin
                dm_cs   = 1'b1;
                dm_rd   = 1'b1;
                dm_addr = {{(32-MEM_AW){1'b0}}, addr_q[MEM_AW-1:2], 2'b00};
            end
            WR: begin
                dm_cs   = 1'b1;
                dm_wr   = 1'b1;
                dm_addr = {{(32-MEM_AW){1'b0}}, addr_q[MEM_AW-1:2], 2'b00};
                dm_din  = merged;
            end
            default: begin
                rsp_valid    = 1'b1;
                rsp_misalign = mis_q;
                rsp_rdata    = (wr_q || mis_q) ? 32'h0 : ld_data;
            end
        endcase
    end

endmodule

// File: tb/tb_load_store_unit.sv
// Self-checking bench for load_store_unit: behavioural big-endian word memory plus a
// scoreboard queue of expected responses pushed at issue and popped on rsp_valid.
module tb_load_store_unit;

    localparam int MEM_AW = 12;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        req_valid, req_ready, req_wr, req_sign;
    logic [1:0]  req_size;
    logic [31:0] req_addr, req_wdata;
    logic        rsp_valid, rsp_misalign;
    logic [31:0] rsp_rdata;
    logic        dm_cs, dm_rd, dm_wr;
    logic [31:0] dm_addr, dm_din, dm_dout;

    load_store_unit #(.MEM_AW(MEM_AW)) dut (
        .clk(clk), .reset_n(reset_n),
        .req_valid(req_valid), .req_ready(req_ready), .req_wr(req_wr),
        .req_size(req_size), .req_sign(req_sign), .req_addr(req_addr),
        .req_wdata(req_wdata), .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata),
        .rsp_misalign(rsp_misalign), .dm_cs(dm_cs), .dm_rd(dm_rd), .dm_wr(dm_wr),
        .dm_addr(dm_addr), .dm_din(dm_din), .dm_dout(dm_dout)
    );

    always #5 clk = ~clk;

    // Word memory: synchronous write, asynchronous read; preload port owned by the stimulus.
    logic [31:0] mem [0:(1<<(MEM_AW-2))-1];
    logic        pre_en = 1'b0;
    logic [MEM_AW-3:0] pre_idx = '0;
    logic [31:0] pre_data = '0;

    always @(posedge clk) begin
        if (pre_en)              mem[pre_idx] <= pre_data;
        else if (dm_cs && dm_wr) mem[dm_addr[MEM_AW-1:2]] <= dm_din;
    end
    assign dm_dout = mem[dm_addr[MEM_AW-1:2]];

    int          cs_cnt = 0, rd_cnt = 0, wr_cnt = 0;
    logic [31:0] last_wr_addr = '0, last_wr_data = '0;
    always @(negedge clk) begin
        if (dm_cs) cs_cnt++;
        if (dm_cs && dm_rd) rd_cnt++;
        if (dm_cs && dm_wr) begin
            wr_cnt++;
            last_wr_addr = dm_addr;
            last_wr_data = dm_din;
        end
    end

    typedef struct {
        string       tag;
        logic [31:0] rdata;
        logic        mis;
        int          lat;
    } exp_t;
    exp_t exp_q[$];

    int tests = 0;
    int fails = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic preload(input logic [31:0] byte_addr, input logic [31:0] data);
        @(negedge clk);
        pre_en   = 1'b1;
        pre_idx  = byte_addr[MEM_AW-1:2];
        pre_data = data;
        @(negedge clk);
        pre_en   = 1'b0;
    endtask

    task automatic do_req(input string tag, input logic wr, input logic [1:0] size,
                          input logic sign, input logic [31:0] addr, input logic [31:0] wdata,
                          input logic [31:0] exp_rdata, input logic exp_mis, input int exp_lat);
        exp_t e;
        bit   got;
        exp_q.push_back('{tag, exp_rdata, exp_mis, exp_lat});
        @(negedge clk);
        check({tag, "_ready"}, {31'b0, req_ready}, 32'd1);
        req_valid = 1'b1;
        req_wr    = wr;
        req_size  = size;
        req_sign  = sign;
        req_addr  = addr;
        req_wdata = wdata;
        @(posedge clk);
        #1 req_valid = 1'b0;
        got = 1'b0;
        for (int k = 1; k <= 8 && !got; k++) begin
            @(negedge clk);
            if (k == 1) check({tag, "_busy"}, {31'b0, req_ready}, 32'd0);
            if (rsp_valid) begin
                got = 1'b1;
                e = exp_q.pop_front();
                check({e.tag, "_rdata"}, rsp_rdata, e.rdata);
                check({e.tag, "_mis"}, {31'b0, rsp_misalign}, {31'b0, e.mis});
                check({e.tag, "_lat"}, k, e.lat);
            end
        end
        check({tag, "_rsp_seen"}, {31'b0, got}, 32'd1);
        if (!got) e = exp_q.pop_front();
        @(negedge clk);
        check({tag, "_pulse"}, {31'b0, rsp_valid}, 32'd0);
    endtask

    int rd0, wr0, cs0;

    initial begin
        reset_n   = 1'b0;
        req_valid = 1'b0;
        req_wr    = 1'b0;
        req_size  = 2'b00;
        req_sign  = 1'b0;
        req_addr  = '0;
        req_wdata = '0;
        repeat (2) @(negedge clk);
        check("rst_ready", {31'b0, req_ready}, 32'd1);
        check("rst_strobes", {28'b0, rsp_valid, rsp_misalign, dm_cs, dm_wr | dm_rd}, 32'd0);
        check("rst_rdata", rsp_rdata, 32'd0);
        check("rst_addr", dm_addr, 32'd0);
        check("rst_din", dm_din, 32'd0);
        reset_n = 1'b1;

        // 1: signed byte load
        preload(32'h010, 32'h8899AABB);
        rd0 = rd_cnt; wr0 = wr_cnt;
        do_req("lb_s_011", 1'b0, 2'b00, 1'b1, 32'h011, 32'h0, 32'hFFFFFF99, 1'b0, 2);
        check("lb_rd_cycles", rd_cnt - rd0, 1);
        check("lb_wr_cycles", wr_cnt - wr0, 0);

        // 2: half and byte loads, both extensions
        preload(32'h010, 32'h8899AABB);
        do_req("lh_u_012", 1'b0, 2'b01, 1'b0, 32'h012, 32'h0, 32'h0000AABB, 1'b0, 2);
        do_req("lh_s_010", 1'b0, 2'b01, 1'b1, 32'h010, 32'h0, 32'hFFFF8899, 1'b0, 2);
        do_req("lb_u_010", 1'b0, 2'b00, 1'b0, 32'h010, 32'h0, 32'h00000088, 1'b0, 2);
        do_req("lb_s_013", 1'b0, 2'b00, 1'b1, 32'h013, 32'h0, 32'hFFFFFFBB, 1'b0, 2);
        do_req("lb_s_012", 1'b0, 2'b00, 1'b1, 32'h012, 32'h0, 32'hFFFFFFAA, 1'b0, 2);

        // 3: sub-word store with read-modify-write
        preload(32'h010, 32'h8899AABB);
        rd0 = rd_cnt; wr0 = wr_cnt;
        do_req("sb_013", 1'b1, 2'b00, 1'b0, 32'h013, 32'hFFFFFF55, 32'h0, 1'b0, 3);
        check("sb_rd_cycles", rd_cnt - rd0, 1);
        check("sb_wr_cycles", wr_cnt - wr0, 1);
        check("sb_din", last_wr_data, 32'h8899AA55);
        check("sb_addr", last_wr_addr, 32'h010);
        do_req("lw_after_sb", 1'b0, 2'b10, 1'b0, 32'h010, 32'h0, 32'h8899AA55, 1'b0, 2);

        // 4: word store, no read cycle
        preload(32'h010, 32'h8899AABB);
        rd0 = rd_cnt; wr0 = wr_cnt;
        do_req("sw_020", 1'b1, 2'b10, 1'b0, 32'h020, 32'h12345678, 32'h0, 1'b0, 2);
        check("sw_rd_cycles", rd_cnt - rd0, 0);
        check("sw_wr_cycles", wr_cnt - wr0, 1);
        check("sw_addr", last_wr_addr, 32'h020);
        check("sw_din", last_wr_data, 32'h12345678);
        check("sw_mem", mem[8], 32'h12345678);

        // Half store into the low lane, and an address that wraps above MEM_AW
        preload(32'h010, 32'h8899AABB);
        do_req("sh_012", 1'b1, 2'b01, 1'b0, 32'h012, 32'h1234CAFE, 32'h0, 1'b0, 3);
        check("sh_din", last_wr_data, 32'h8899CAFE);
        do_req("lw_wrap", 1'b0, 2'b11, 1'b0, 32'h0000_1010, 32'h0, 32'h8899CAFE, 1'b0, 2);

        // 5: misaligned word load
        preload(32'h010, 32'h8899AABB);
        cs0 = cs_cnt;
`ifdef LSU_ALIGN_TRAP_EN
        do_req("lw_mis_012", 1'b0, 2'b10, 1'b0, 32'h012, 32'h0, 32'h0, 1'b1, 1);
        check("mis_no_cs", cs_cnt - cs0, 0);
        cs0 = cs_cnt;
        do_req("sh_mis_011", 1'b1, 2'b01, 1'b0, 32'h011, 32'h7777, 32'h0, 1'b1, 1);
        check("mis_sh_no_cs", cs_cnt - cs0, 0);
        check("mis_sh_mem", mem[4], 32'h8899AABB);
`else
        do_req("lw_012", 1'b0, 2'b10, 1'b0, 32'h012, 32'h0, 32'h8899AABB, 1'b0, 2);
        check("lw_012_cs", cs_cnt - cs0, 1);
        do_req("lh_u_011", 1'b0, 2'b01, 1'b0, 32'h011, 32'h0, 32'h00008899, 1'b0, 2);
`endif

        // 6: reset during the read phase of a byte store
        preload(32'h010, 32'h8899AABB);
        wr0 = wr_cnt;
        @(negedge clk);
        req_valid = 1'b1;
        req_wr    = 1'b1;
        req_size  = 2'b00;
        req_sign  = 1'b0;
        req_addr  = 32'h010;
        req_wdata = 32'h00000011;
        @(posedge clk);
        #1 req_valid = 1'b0;
        check("rst_mid_rd_phase", {31'b0, dm_rd}, 32'd1);
        #2 reset_n = 1'b0;
        #1 check("rst_mid_cs_drop", {29'b0, dm_cs, dm_rd, dm_wr}, 32'd0);
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        repeat (3) @(negedge clk);
        check("rst_mid_no_wr", wr_cnt - wr0, 0);
        check("rst_mid_mem", mem[4], 32'h8899AABB);
        check("rst_mid_ready", {31'b0, req_ready}, 32'd1);
        check("rst_mid_no_rsp", {31'b0, rsp_valid}, 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
